// File: rtl/vga_sync_rx.sv
// VGA receive front end: measures line/frame periods, locks onto stable timing, emits active-area pixels.
// Optional sync polarity auto-detection is built when VGA_RX_POLARITY_DETECT_EN is defined.
module vga_sync_rx #(
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 36,
  parameter int V_ACTIVE = 480
) (
  input  logic        VGA_CLK_IN,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic [23:0] rgb_out,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total
);

  localparam logic [9:0] H_LO    = 10'(H_START);
  localparam logic [9:0] H_HI    = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_LO    = 10'(V_START);
  localparam logic [9:0] V_HI    = 10'(V_START + V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCKED} state_t;
  state_t state;

  logic        hs_s, vs_s, hs_d, vs_d;
  logic        hs_c, vs_c, pol_flip;
  logic [23:0] rgb_s, rgb_d;
  logic [9:0]  h_cnt, v_cnt, ref_h, ref_v;
  logic        seen_edge, frame_pending;

  logic        hs_rise, vs_rise, frame_edge, timeout;
  logic [9:0]  h_meas, v_meas, h_new, v_new, h_cnt_nxt;
  logic        h_act, v_act, pix_ok;

  // Edge history holds the polarity-corrected syncs; rgb gets one extra stage to line up with h_cnt.
  always_ff @(posedge VGA_CLK_IN or negedge reset) begin
    if (!reset) begin
      hs_s  <= 1'b0;
      vs_s  <= 1'b0;
      hs_d  <= 1'b0;
      vs_d  <= 1'b0;
      rgb_s <= '0;
      rgb_d <= '0;
    end else begin
      hs_s  <= hsync;
      vs_s  <= vsync;
      hs_d  <= hs_c;
      vs_d  <= vs_c;
      rgb_s <= {red, green, blue};
      rgb_d <= rgb_s;
    end
  end

  assign hs_rise    = hs_c & ~hs_d;
  assign vs_rise    = vs_c & ~vs_d;
  assign frame_edge = hs_rise & (frame_pending | vs_rise);
  assign h_meas     = h_cnt + 10'd1;
  assign v_meas     = v_cnt + 10'd1;
  assign h_new      = (hs_rise && seen_edge) ? h_meas : h_total;
  assign v_new      = frame_edge ? v_meas : v_total;
  assign h_cnt_nxt  = hs_rise ? '0 : ((h_cnt == CNT_MAX) ? CNT_MAX : h_meas);
  assign timeout    = (h_cnt_nxt == CNT_MAX);

`ifdef VGA_RX_POLARITY_DETECT_EN
  logic       hs_inv, vs_inv, hs_pol_new, vs_pol_new;
  logic [9:0] hs_hi, vs_hi;

  assign hs_c       = hs_s ^ hs_inv;
  assign vs_c       = vs_s ^ vs_inv;
  // A sync that is high for more than half its period is really an active-low pulse.
  assign hs_pol_new = hs_hi > (h_meas >> 1);
  assign vs_pol_new = vs_hi > (v_meas >> 1);
  assign pol_flip   = (hs_rise & seen_edge & (hs_pol_new != hs_inv)) |
                      (frame_edge & (vs_pol_new != vs_inv));

  always_ff @(posedge VGA_CLK_IN or negedge reset) begin
    if (!reset) begin
      hs_inv <= 1'b0;
      vs_inv <= 1'b0;
      hs_hi  <= '0;
      vs_hi  <= '0;
    end else begin
      if (hs_rise)
        hs_hi <= {9'd0, hs_s};
      else if (hs_hi != CNT_MAX)
        hs_hi <= hs_hi + {9'd0, hs_s};
      if (hs_rise && seen_edge)
        hs_inv <= hs_pol_new;
      if (frame_edge) begin
        vs_hi  <= {9'd0, vs_s};
        vs_inv <= vs_pol_new;
      end else if (hs_rise && vs_hi != CNT_MAX) begin
        vs_hi <= vs_hi + {9'd0, vs_s};
      end
    end
  end
`else
  assign hs_c     = hs_s;
  assign vs_c     = vs_s;
  assign pol_flip = 1'b0;
`endif

  always_ff @(posedge VGA_CLK_IN or negedge reset) begin
    if (!reset) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      seen_edge     <= 1'b0;
      frame_pending <= 1'b0;
      h_total       <= '0;
      v_total       <= '0;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      h_cnt       <= h_cnt_nxt;
      line_start  <= hs_rise;
      frame_start <= frame_edge;
      h_total     <= h_new;
      v_total     <= v_new;
      if (hs_rise)
        seen_edge <= 1'b1;
      if (frame_edge) begin
        v_cnt         <= '0;
        frame_pending <= 1'b0;
      end else begin
        if (hs_rise && v_cnt != CNT_MAX)
          v_cnt <= v_meas;
        if (vs_rise)
          frame_pending <= 1'b1;
      end
    end
  end

  // Lock decisions use the values being written to h_total/v_total this cycle.
  always_ff @(posedge VGA_CLK_IN or negedge reset) begin
    if (!reset) begin
      state  <= ST_SEARCH;
      locked <= 1'b0;
      ref_h  <= '0;
      ref_v  <= '0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (frame_edge) begin
            ref_h <= h_new;
            ref_v <= v_new;
            state <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (frame_edge) begin
            if (h_new == ref_h && v_new == ref_v) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end else begin
              ref_h <= h_new;
              ref_v <= v_new;
            end
          end
        end
        ST_LOCKED: begin
          if ((hs_rise && h_new != ref_h) || (frame_edge && v_new != ref_v) ||
              timeout || pol_flip) begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  assign h_act  = (h_cnt >= H_LO) && (h_cnt < H_HI);
  assign v_act  = (v_cnt >= V_LO) && (v_cnt < V_HI);
  assign pix_ok = locked & h_act & v_act;

  always_ff @(posedge VGA_CLK_IN or negedge reset) begin
    if (!reset) begin
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      rgb_out     <= '0;
    end else begin
      pixel_valid <= pix_ok;
      pixel_x     <= pix_ok ? (h_cnt - H_LO) : '0;
      pixel_y     <= pix_ok ? (v_cnt - V_LO) : '0;
      rgb_out     <= rgb_d;
    end
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a shrunken source timing (160 clk/line, 10 lines/frame).
module tb_vga_sync_rx;
  localparam int LINE    = 160;
  localparam int NL      = 10;
  localparam int HS_LAST = 15;
  localparam int HS0     = 20;
  localparam int HA      = 100;
  localparam int VS0     = 3;
  localparam int VA      = 4;
  localparam int TO_X    = 1025 - LINE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hsync = 1'b0, vsync = 1'b0;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic [9:0]  pixel_x, pixel_y, h_total, v_total;
  logic        pixel_valid, line_start, frame_start, locked;
  logic [23:0] rgb_out;

  vga_sync_rx #(.H_START(HS0), .H_ACTIVE(HA), .V_START(VS0), .V_ACTIVE(VA)) dut (
    .VGA_CLK_IN(clk), .reset(rst_n), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid), .rgb_out(rgb_out),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .h_total(h_total), .v_total(v_total)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ls_cnt = 0;
  int fs_cnt = 0;
  int lock_low = 0;
  bit inv_pol = 1'b0;

  // Control outputs indexed by drive position; pixel outputs indexed by source pixel (3 clocks earlier).
  logic        s_lock [0:1199];
  logic        s_ls   [0:1199];
  logic        s_fs   [0:1199];
  logic [9:0]  s_ht   [0:1199];
  logic [9:0]  s_vt   [0:1199];
  logic        c_vld  [0:1199];
  logic [9:0]  c_px   [0:1199];
  logic [9:0]  c_py   [0:1199];
  logic [23:0] c_rgb  [0:1199];

  function automatic logic [23:0] pat(input int l, input int x);
    if (l == 3 && x == HS0 + 1) return 24'hF245C0;
    return {x[7:0], l[7:0], 8'hA5};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_pixel_x"},     32'(pixel_x),     0);
    chk({pfx, "_pixel_y"},     32'(pixel_y),     0);
    chk({pfx, "_pixel_valid"}, 32'(pixel_valid), 0);
    chk({pfx, "_rgb_out"},     32'(rgb_out),     0);
    chk({pfx, "_line_start"},  32'(line_start),  0);
    chk({pfx, "_frame_start"}, 32'(frame_start), 0);
    chk({pfx, "_locked"},      32'(locked),      0);
    chk({pfx, "_h_total"},     32'(h_total),     0);
    chk({pfx, "_v_total"},     32'(v_total),     0);
  endtask

  task automatic drive_line(input int l, input int x0, input int x1, input bit hs_on);
    for (int x = x0; x <= x1; x++) begin
      @(negedge clk);
      s_lock[x] = locked;
      s_ls[x]   = line_start;
      s_fs[x]   = frame_start;
      s_ht[x]   = h_total;
      s_vt[x]   = v_total;
      ls_cnt   += int'(line_start);
      fs_cnt   += int'(frame_start);
      if (!locked) lock_low++;
      if (x >= 3) begin
        c_vld[x-3] = pixel_valid;
        c_px[x-3]  = pixel_x;
        c_py[x-3]  = pixel_y;
        c_rgb[x-3] = rgb_out;
      end
      hsync = inv_pol ^ (hs_on && x >= 1 && x <= HS_LAST);
      vsync = inv_pol ^ (l < 2);
      {red, green, blue} = pat(l, x);
    end
  endtask

  task automatic run_lines(input int first, input int last);
    for (int l = first; l <= last; l++) drive_line(l, 0, LINE - 1, 1'b1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #3 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // frame 0: first boundary, measurements not yet meaningful
    ls_cnt = 0; fs_cnt = 0;
    drive_line(0, 0, LINE - 1, 1'b1);
    chk("f0_fs_early", 32'(s_fs[2]), 0);
    chk("f0_fs", 32'(s_fs[3]), 1);
    chk("f0_ls", 32'(s_ls[3]), 1);
    chk("f0_unlocked", 32'(s_lock[3]), 0);
    run_lines(1, NL - 1);
    chk("f0_line_count", 32'(ls_cnt), NL);
    chk("f0_frame_count", 32'(fs_cnt), 1);

    // frame 1: first full measurement
    drive_line(0, 0, LINE - 1, 1'b1);
    chk("f1_unlocked", 32'(s_lock[3]), 0);
    chk("f1_h_total", 32'(s_ht[3]), LINE);
    chk("f1_v_total", 32'(s_vt[3]), NL);
    run_lines(1, NL - 1);

    // frame 2: repeat measurement confirms -> lock
    drive_line(0, 0, LINE - 1, 1'b1);
    chk("f2_lock_before", 32'(s_lock[2]), 0);
    chk("f2_lock_rise", 32'(s_lock[3]), 1);
    run_lines(1, NL - 1);

    // frame 3: pixel window boundaries
    lock_low = 0;
    run_lines(0, 2);
    drive_line(3, 0, LINE - 1, 1'b1);
    chk("px_before_vld", 32'(c_vld[HS0]), 0);
    chk("px_before_x", 32'(c_px[HS0]), 0);
    chk("px_first_vld", 32'(c_vld[HS0+1]), 1);
    chk("px_first_x", 32'(c_px[HS0+1]), 0);
    chk("px_first_y", 32'(c_py[HS0+1]), 0);
    chk("px_first_rgb", 32'(c_rgb[HS0+1]), 32'h00F245C0);
    chk("px_second_x", 32'(c_px[HS0+2]), 1);
    chk("px_last_vld", 32'(c_vld[HS0+HA]), 1);
    chk("px_last_x", 32'(c_px[HS0+HA]), HA - 1);
    chk("px_last_rgb", 32'(c_rgb[HS0+HA]), 32'(pat(3, HS0 + HA)));
    chk("px_after_vld", 32'(c_vld[HS0+HA+1]), 0);
    run_lines(4, 5);
    drive_line(VS0 + VA - 1, 0, LINE - 1, 1'b1);
    chk("py_last_vld", 32'(c_vld[HS0+1]), 1);
    chk("py_last_y", 32'(c_py[HS0+1]), VA - 1);
    drive_line(VS0 + VA, 0, LINE - 1, 1'b1);
    chk("py_after_vld", 32'(c_vld[HS0+1]), 0);
    chk("py_after_y", 32'(c_py[HS0+1]), 0);
    run_lines(8, NL - 1);

    // frames 4-5: lock must hold throughout
    for (int f = 0; f < 2; f++) run_lines(0, NL - 1);
    chk("lock_held", 32'(lock_low), 0);

    // frame 6: one short line breaks lock at the following edge
    run_lines(0, 3);
    drive_line(4, 0, LINE - 2, 1'b1);
    drive_line(5, 0, LINE - 1, 1'b1);
    chk("short_lock_edge", 32'(s_lock[2]), 1);
    chk("short_lock_drop", 32'(s_lock[3]), 0);
    chk("short_h_total", 32'(s_ht[3]), LINE - 1);
    run_lines(6, NL - 1);
    drive_line(0, 0, LINE - 1, 1'b1);
    chk("short_track", 32'(s_lock[3]), 0);
    run_lines(1, NL - 1);
    drive_line(0, 0, LINE - 1, 1'b1);
    chk("short_relock", 32'(s_lock[3]), 1);

    // frame 8: hsync held low until h_cnt saturates
    run_lines(1, 4);
    ls_cnt = 0;
    drive_line(5, 0, 1099, 1'b0);
    chk("hold_lock_pre", 32'(s_lock[TO_X]), 1);
    chk("hold_lock_drop", 32'(s_lock[TO_X+1]), 0);
    chk("hold_no_ls", 32'(ls_cnt), 0);
    run_lines(6, NL - 1);
    run_lines(0, NL - 1);
    run_lines(0, NL - 1);
    drive_line(0, 0, LINE - 1, 1'b1);
    chk("hold_relock", 32'(s_lock[3]), 1);

    // frame 11: asynchronous reset mid-line
    run_lines(1, 4);
    drive_line(5, 0, 79, 1'b1);
    #5 rst_n = 1'b0;
    #1 chk_zero("midreset");
    #5 rst_n = 1'b1;
    drive_line(5, 80, LINE - 1, 1'b1);
    run_lines(6, NL - 1);
    drive_line(0, 0, LINE - 1, 1'b1);
    chk("rst_f1_fs", 32'(s_fs[3]), 1);
    chk("rst_f1_lock", 32'(s_lock[3]), 0);
    run_lines(1, NL - 1);
    drive_line(0, 0, LINE - 1, 1'b1);
    chk("rst_f2_lock", 32'(s_lock[3]), 0);
    run_lines(1, NL - 1);
    drive_line(0, 0, LINE - 1, 1'b1);
    chk("rst_relock", 32'(s_lock[3]), 1);
    run_lines(1, NL - 1);

`ifdef VGA_RX_POLARITY_DETECT_EN
    // inverted syncs must be measured and locked just like normal ones
    inv_pol = 1'b1;
    for (int f = 0; f < 5; f++) run_lines(0, NL - 1);
    drive_line(0, 0, LINE - 1, 1'b1);
    chk("inv_locked", 32'(s_lock[3]), 1);
    chk("inv_h_total", 32'(s_ht[3]), LINE);
    chk("inv_v_total", 32'(s_vt[3]), NL);
    run_lines(1, NL - 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
